// File: rtl/crossing_pkg.sv
// Shared types and defaults for the crossing gate sequencer.
// Holds the FSM state enum, default timings and counter sizing helpers.
package crossing_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARN,
    LOWERING,
    CLOSED,
    HOLD,
    RAISING,
    FAULT
  } state_e;

  localparam int unsigned WARN_CYCLES_D   = 8;
  localparam int unsigned MOTOR_TIMEOUT_D = 16;
  localparam int unsigned CLEAR_HOLD_D    = 4;
  localparam int unsigned BLINK_HALF_D    = 2;

  function automatic int cnt_w(input int unsigned m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/crossing_flasher.sv
// Alternating two-lamp flasher; phase held at 1 while disabled
// so lamp A lights on the first enabled cycle.
module crossing_flasher
  import crossing_pkg::*;
#(
  parameter int unsigned BLINK_HALF = BLINK_HALF_D
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic lamp_a,
  output logic lamp_b
);

  localparam int CW = cnt_w(BLINK_HALF);
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign lamp_a = en & r_phase;
  assign lamp_b = en & ~r_phase;

endmodule

// File: rtl/crossing_gate_seq.sv
// Barrier/lamp sequencer: warn, lower, hold, clear, raise, with fault latch.
// Define CROSSING_BELL_EN to add the bell output.
module crossing_gate_seq
  import crossing_pkg::*;
#(
  parameter int unsigned WARN_CYCLES   = WARN_CYCLES_D,
  parameter int unsigned MOTOR_TIMEOUT = MOTOR_TIMEOUT_D,
  parameter int unsigned CLEAR_HOLD    = CLEAR_HOLD_D,
  parameter int unsigned BLINK_HALF    = BLINK_HALF_D
) (
  input  logic clk,
  input  logic rst,
  input  logic gx,
  input  logic gy,
  input  logic down_lim,
  input  logic up_lim,
  output logic motor_down,
  output logic motor_up,
  output logic lamp_a,
  output logic lamp_b,
  output logic gate_closed,
  output logic fault
`ifdef CROSSING_BELL_EN
  ,
  output logic bell
`endif
);

  localparam int CW =
    cnt_w(max3(WARN_CYCLES, MOTOR_TIMEOUT, CLEAR_HOLD));
  localparam logic [CW-1:0] WARN_LAST  = CW'(WARN_CYCLES - 1);
  localparam logic [CW-1:0] MOTOR_LAST = CW'(MOTOR_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CLEAR_HOLD - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_req;
  logic          w_both;
  logic          w_lights;

  assign w_req  = gx | gy;
  assign w_both = up_lim & down_lim;

  // Counter clears on every transition; only staying branches count up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_both) begin
      r_state <= FAULT;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_req) r_state <= WARN;
        end
        WARN: begin
          if (!w_req) r_state <= IDLE;
          else if (r_cnt == WARN_LAST) r_state <= LOWERING;
          else r_cnt <= r_cnt + CW'(1);
        end
        LOWERING: begin
          if (down_lim) r_state <= CLOSED;
          else if (r_cnt == MOTOR_LAST) r_state <= FAULT;
          else r_cnt <= r_cnt + CW'(1);
        end
        CLOSED: begin
          if (!w_req) r_state <= HOLD;
        end
        HOLD: begin
          if (w_req) r_state <= CLOSED;
          else if (r_cnt == HOLD_LAST) r_state <= RAISING;
          else r_cnt <= r_cnt + CW'(1);
        end
        RAISING: begin
          if (w_req) r_state <= LOWERING;
          else if (up_lim) r_state <= IDLE;
          else if (r_cnt == MOTOR_LAST) r_state <= FAULT;
          else r_cnt <= r_cnt + CW'(1);
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= FAULT;
        end
      endcase
    end
  end

  assign motor_down  = (r_state == LOWERING);
  assign motor_up    = (r_state == RAISING);
  assign gate_closed = (r_state == CLOSED) || (r_state == HOLD);
  assign fault       = (r_state == FAULT);
  assign w_lights    = (r_state != IDLE);

`ifdef CROSSING_BELL_EN
  assign bell = (r_state == WARN) || (r_state == LOWERING)
             || (r_state == RAISING);
`endif

  crossing_flasher #(
    .BLINK_HALF(BLINK_HALF)
  ) u_flasher (
    .clk   (clk),
    .rst   (rst),
    .en    (w_lights),
    .lamp_a(lamp_a),
    .lamp_b(lamp_b)
  );

endmodule

// File: tb/tb_crossing_gate_seq.sv
// Scoreboard bench for crossing_gate_seq: directed per-cycle vectors
// with hand-derived expected states, checked by a negedge monitor.
module tb_crossing_gate_seq;

  localparam int BH = 2;
  localparam int S_I = 0;
  localparam int S_W = 1;
  localparam int S_L = 2;
  localparam int S_C = 3;
  localparam int S_H = 4;
  localparam int S_R = 5;
  localparam int S_F = 6;

  logic clk;
  logic rst;
  logic gx;
  logic gy;
  logic down_lim;
  logic up_lim;
  logic motor_down;
  logic motor_up;
  logic lamp_a;
  logic lamp_b;
  logic gate_closed;
  logic fault;
`ifdef CROSSING_BELL_EN
  logic bell;
`endif

  logic [6:0] q[$];
  int n_on;
  int checks;
  int errors;

  crossing_gate_seq dut (
    .clk        (clk),
    .rst        (rst),
    .gx         (gx),
    .gy         (gy),
    .down_lim   (down_lim),
    .up_lim     (up_lim),
    .motor_down (motor_down),
    .motor_up   (motor_up),
    .lamp_a     (lamp_a),
    .lamp_b     (lamp_b),
    .gate_closed(gate_closed),
    .fault      (fault)
`ifdef CROSSING_BELL_EN
    ,
    .bell       (bell)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {motor_down, motor_up, lamp_a, lamp_b, gate_closed, fault, bell}
  function automatic logic [6:0] exp_out(input int st, input int n);
    logic on;
    logic ph;
    on = (st != S_I);
    ph = ((n / BH) % 2) == 0;
    return {st == S_L, st == S_R, on & ph, on & ~ph,
            (st == S_C) || (st == S_H), st == S_F,
            (st == S_W) || (st == S_L) || (st == S_R)};
  endfunction

  // Drive this cycle's inputs; st is the state expected in this cycle.
  task automatic cyc(input logic r, input logic a, input logic b,
                     input logic dl, input logic ul, input int st);
    @(posedge clk);
    #1;
    rst = r;
    gx = a;
    gy = b;
    down_lim = dl;
    up_lim = ul;
    if (st == S_I) n_on = 0;
    q.push_back(exp_out(st, n_on));
    if (st != S_I) n_on++;
  endtask

  task automatic rep(input int k, input logic r, input logic a,
                     input logic b, input logic dl, input logic ul,
                     input int st);
    for (int i = 0; i < k; i++) cyc(r, a, b, dl, ul, st);
  endtask

  always @(negedge clk) begin
    logic [6:0] want;
    logic [6:0] got;
    if (q.size() != 0) begin
      want = q.pop_front();
`ifdef CROSSING_BELL_EN
      got = {motor_down, motor_up, lamp_a, lamp_b,
             gate_closed, fault, bell};
`else
      got = {motor_down, motor_up, lamp_a, lamp_b,
             gate_closed, fault, 1'b0};
      want[0] = 1'b0;
`endif
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outs chk%0d t=%0t got=%b want=%b",
                 checks, $time, got, want);
      end
    end
  end

  initial begin
    rst = 1'b1;
    gx = 1'b0;
    gy = 1'b0;
    down_lim = 1'b0;
    up_lim = 1'b0;
    n_on = 0;
    checks = 0;
    errors = 0;

    // reset, then full close/open cycle
    cyc(1, 0, 0, 0, 0, S_I);
    cyc(0, 0, 0, 0, 0, S_I);
    cyc(0, 1, 0, 0, 0, S_I);
    rep(8, 0, 1, 0, 0, 0, S_W);
    rep(3, 0, 1, 0, 0, 0, S_L);
    cyc(0, 1, 0, 1, 0, S_L);
    rep(2, 0, 1, 0, 1, 0, S_C);
    cyc(0, 0, 0, 1, 0, S_C);
    rep(4, 0, 0, 0, 1, 0, S_H);
    rep(2, 0, 0, 0, 0, 0, S_R);
    cyc(0, 0, 0, 0, 1, S_R);
    rep(2, 0, 0, 0, 0, 0, S_I);

    // short gy pulse aborts the warning
    cyc(0, 0, 1, 0, 0, S_I);
    rep(2, 0, 0, 1, 0, 0, S_W);
    cyc(0, 0, 0, 0, 0, S_W);
    rep(2, 0, 0, 0, 0, 0, S_I);

    // request beats up_lim while raising, then lowering timeout
    cyc(0, 1, 0, 0, 0, S_I);
    rep(8, 0, 1, 0, 0, 0, S_W);
    cyc(0, 1, 0, 1, 0, S_L);
    cyc(0, 0, 0, 1, 0, S_C);
    rep(4, 0, 0, 0, 1, 0, S_H);
    cyc(0, 1, 0, 0, 1, S_R);
    cyc(0, 1, 0, 0, 0, S_L);
    cyc(0, 1, 0, 1, 0, S_L);
    cyc(0, 0, 0, 1, 0, S_C);
    rep(4, 0, 0, 0, 1, 0, S_H);
    cyc(0, 1, 0, 0, 0, S_R);
    rep(16, 0, 1, 0, 0, 0, S_L);
    rep(2, 0, 0, 0, 0, 1, S_F);
    rep(2, 0, 1, 1, 0, 0, S_F);
    cyc(1, 0, 0, 0, 0, S_F);
    cyc(0, 0, 0, 0, 0, S_I);

    // down_lim on the timeout cycle, HOLD re-close, reset mid-lowering
    cyc(0, 1, 0, 0, 0, S_I);
    rep(8, 0, 1, 0, 0, 0, S_W);
    rep(15, 0, 1, 0, 0, 0, S_L);
    cyc(0, 1, 0, 1, 0, S_L);
    cyc(0, 0, 0, 1, 0, S_C);
    cyc(0, 1, 0, 1, 0, S_H);
    cyc(0, 0, 0, 1, 0, S_C);
    rep(4, 0, 0, 0, 1, 0, S_H);
    cyc(0, 0, 0, 0, 0, S_R);
    cyc(0, 1, 0, 0, 0, S_R);
    cyc(1, 1, 0, 0, 0, S_L);
    cyc(0, 0, 0, 0, 0, S_I);

    // both limit switches in IDLE
    cyc(0, 0, 0, 1, 1, S_I);
    rep(3, 0, 0, 0, 0, 0, S_F);
    cyc(1, 0, 0, 0, 0, S_F);
    cyc(0, 0, 0, 0, 0, S_I);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
